// File: rtl/mips_pkg.sv
// Shared register-index constants and the destination-select encoding
// for the write-register destination path.
package mips_pkg;

  localparam int REG_W   = 5;
  localparam int NUM_SRC = 3;
  localparam int SEL_W   = 3;

  localparam logic [REG_W-1:0] REG_RA   = 5'd31;
  localparam logic [REG_W-1:0] REG_SP   = 5'd29;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  // Encoding for the default NUM_SRC; wider configurations keep the same
  // order (instruction fields first, then $ra, then $sp).
  typedef enum logic [SEL_W-1:0] {
    FIELD_0 = 3'd0,
    FIELD_1 = 3'd1,
    FIELD_2 = 3'd2,
    SEL_RA  = 3'd3,
    SEL_SP  = 3'd4
  } dest_sel_t;

endpackage

// File: rtl/dest_sel_mux.sv
// Combinational destination select: an instruction field, $ra or $sp,
// with a flag telling whether sel names a defined source.
module dest_sel_mux #(
  parameter int REG_W   = 5,
  parameter int NUM_SRC = 3,
  parameter int SEL_W   = 3
) (
  input  logic [SEL_W-1:0]         sel_i,
  input  logic [NUM_SRC*REG_W-1:0] fields_i,
  output logic [REG_W-1:0]         dest_o,
  output logic                     legal_o
);
  import mips_pkg::*;

  localparam logic [SEL_W-1:0] SEL_RA_IDX = SEL_W'(NUM_SRC);
  localparam logic [SEL_W-1:0] SEL_SP_IDX = SEL_W'(NUM_SRC + 1);

  always_comb begin
    dest_o  = '0;
    legal_o = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel_i == SEL_W'(k)) begin
        dest_o  = fields_i[k*REG_W +: REG_W];
        legal_o = 1'b1;
      end
    end
    if (sel_i == SEL_RA_IDX) begin
      dest_o  = REG_W'(REG_RA);
      legal_o = 1'b1;
    end
    if (sel_i == SEL_SP_IDX) begin
      dest_o  = REG_W'(REG_SP);
      legal_o = 1'b1;
    end
  end

endmodule

// File: rtl/write_reg_dest_pipe.sv
// Write-register destination select carried through STAGES pipeline slots,
// with writeback outputs and youngest-match forwarding indices for rs/rt.
module write_reg_dest_pipe #(
  parameter int REG_W   = 5,
  parameter int NUM_SRC = 3,
  parameter int STAGES  = 3,
  parameter int SEL_W   = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic                         reg_write,
  input  logic [SEL_W-1:0]             sel,
  input  logic [NUM_SRC*REG_W-1:0]     fields,
  input  logic [REG_W-1:0]             rs_addr,
  input  logic [REG_W-1:0]             rt_addr,
  output logic [REG_W-1:0]             dest_comb,
  output logic                         illegal_sel,
  output logic [STAGES*REG_W-1:0]      slot_dest,
  output logic [STAGES-1:0]            slot_wen,
  output logic [REG_W-1:0]             wb_dest,
  output logic                         wb_wen,
  output logic [$clog2(STAGES+1)-1:0]  fwd_rs,
  output logic [$clog2(STAGES+1)-1:0]  fwd_rt
);
  import mips_pkg::*;

  localparam int FWD_W = $clog2(STAGES + 1);

  logic sel_legal;
  logic cap_wen;
  logic illegal_q, illegal_d;

  dest_sel_mux #(
    .REG_W   (REG_W),
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_dest_sel_mux (
    .sel_i    (sel),
    .fields_i (fields),
    .dest_o   (dest_comb),
    .legal_o  (sel_legal)
  );

  assign cap_wen = in_valid & reg_write & sel_legal & (dest_comb != REG_W'(REG_ZERO));

  for (genvar i = 0; i < STAGES; i++) begin : g_slot
    logic [REG_W-1:0] dest_q, dest_d;
    logic             wen_q, wen_d;
    logic [REG_W-1:0] prev_dest;
    logic             prev_wen;
    logic             kill;
    logic             hold;

    if (i == 0) begin : g_head
      assign prev_dest = dest_comb;
      assign prev_wen  = cap_wen;
    end else begin : g_body
      assign prev_dest = slot_dest[(i-1)*REG_W +: REG_W];
      assign prev_wen  = slot_wen[i-1];
    end

    // Writeback keeps advancing under flush so the retiring entry is not lost;
    // a single-slot pipe has nothing upstream to flush.
    if (i == STAGES-1) begin : g_wb
      assign kill = 1'b0;
      if (STAGES > 1) begin : g_multi
        assign hold = stall & ~flush;
      end else begin : g_single
        assign hold = stall;
      end
    end else begin : g_mid
      assign kill = flush;
      assign hold = stall;
    end

    always_comb begin
      dest_d = prev_dest;
      wen_d  = prev_wen;
      if (kill) begin
        dest_d = '0;
        wen_d  = 1'b0;
      end else if (hold) begin
        dest_d = dest_q;
        wen_d  = wen_q;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        dest_q <= '0;
        wen_q  <= 1'b0;
      end else begin
        dest_q <= dest_d;
        wen_q  <= wen_d;
      end
    end

    assign slot_dest[i*REG_W +: REG_W] = dest_q;
    assign slot_wen[i]                 = wen_q;
  end

  assign illegal_d = illegal_q | (in_valid & ~stall & ~flush & ~sel_legal);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign illegal_sel = illegal_q;
  assign wb_dest     = slot_dest[(STAGES-1)*REG_W +: REG_W];
  assign wb_wen      = slot_wen[STAGES-1];

  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    fwd_rs = '0;
    fwd_rt = '0;
    for (int i = STAGES-1; i >= 0; i--) begin
      if (slot_wen[i] && (slot_dest[i*REG_W +: REG_W] == rs_addr) && (rs_addr != '0)) begin
        fwd_rs = FWD_W'(i + 1);
      end
      if (slot_wen[i] && (slot_dest[i*REG_W +: REG_W] == rt_addr) && (rt_addr != '0)) begin
        fwd_rt = FWD_W'(i + 1);
      end
    end
  end

endmodule
